button_debouncer: RTL and testbench

Multi-channel mechanical-button conditioner for the elevator call/floor panel. Each raw, asynchronous button pin is synchronised into `clk`, filtered by a per-channel counter-based state machine, and presented as a clean debounced level. That level drives the `cp` input of the per-button `edge_detector` stage directly downstream. An optional long-press pulse per channel is compiled in by macro.

---
 rtl/button_debouncer.sv | 186 ++++++++++++++++++
 tb/tb_button_debouncer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel button synchroniser, debounce filter and long-press flag
//
// Purpose:
//   Conditions BTN_W raw mechanical button pins for the elevator call/floor
//   panel. Each pin passes through a 2-FF synchroniser and a per-channel
//   counter-based filter FSM; the accepted level is registered on btn_level
//   and feeds the cp input of the downstream edge_detector stage.
//
// Optional feature:
//   `define BUTTON_DEBOUNCER_LONG_PRESS_EN adds a per-channel long-press
//   counter that emits a one-cycle btn_long pulse once the debounced level
//   has been high for LONG_CYC cycles. Without the macro btn_long is tied 0.
//
// Parameters:
//   BTN_W        number of independent button channels
//   CNT_W        debounce counter width, 2**CNT_W > DEBOUNCE_CYC
//   DEBOUNCE_CYC consecutive stable cycles needed to accept a change (>= 2)
//   LONG_CNT_W   long-press counter width, 2**LONG_CNT_W > LONG_CYC
//   LONG_CYC     cycles of high level that flag a long press (>= 2)
//
// Ports:
//   clk        system clock, all state on its rising edge
//   reset_n    synchronous active-low reset
//   btn_raw    raw asynchronous button pins, active-high
//   btn_level  debounced level per channel, registered
//   btn_long   one-cycle long-press pulse per channel, registered

module button_debouncer #(
   parameter int BTN_W        = 4,
   parameter int CNT_W        = 20,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CNT_W   = 27,
   parameter int LONG_CYC     = 100_000_000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [BTN_W-1:0] btn_raw,
   output logic [BTN_W-1:0] btn_level,
   output logic [BTN_W-1:0] btn_long
);

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_RISE_CHK = 2'd1,
      S_HIGH     = 2'd2,
      S_FALL_CHK = 2'd3
   } state_t;

   // Last count value inside a CHK state; reaching it on a stable sample
   // completes DEBOUNCE_CYC stable cycles and accepts the new level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   // Reject configurations whose counters could wrap or whose thresholds
   // are too small for the filter to mean anything.
   if (DEBOUNCE_CYC < 2 || (DEBOUNCE_CYC >> CNT_W) != 0) begin : g_bad_debounce_cfg
      $error("button_debouncer: DEBOUNCE_CYC must be >= 2 and < 2**CNT_W");
   end
   if (LONG_CYC < 2 || (LONG_CYC >> LONG_CNT_W) != 0) begin : g_bad_long_cfg
      $error("button_debouncer: LONG_CYC must be >= 2 and < 2**LONG_CNT_W");
   end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   localparam logic [LONG_CNT_W-1:0] LONG_MAX  = LONG_CNT_W'(LONG_CYC);
   localparam logic [LONG_CNT_W-1:0] LONG_LAST = LONG_CNT_W'(LONG_CYC - 1);
`else
   assign btn_long = '0;
`endif

   for (genvar i = 0; i < BTN_W; i++) begin : g_ch

      logic             sync1;
      logic             sync2;
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             level;
      logic             level_nxt;

      // Two-flop synchroniser; only sync2 is ever looked at by the filter.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
         end else begin
            sync1 <= btn_raw[i];
            sync2 <= sync1;
         end
      end

      // Filter state register. The level is held in its own flop so the
      // output is a clean register rather than a decode of the state.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
         end
      end

      // Next-state logic. Any sample that disagrees with the candidate
      // level during a CHK state drops back to the settled state with the
      // count cleared, so a change is only accepted after an unbroken run.
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         level_nxt = level;
         case (state)
            S_LOW: begin
               if (sync2) begin
                  state_nxt = S_RISE_CHK;
                  cnt_nxt   = '0;
               end
            end
            S_RISE_CHK: begin
               if (!sync2) begin
                  state_nxt = S_LOW;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = S_HIGH;
                  level_nxt = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            S_HIGH: begin
               if (!sync2) begin
                  state_nxt = S_FALL_CHK;
                  cnt_nxt   = '0;
               end
            end
            S_FALL_CHK: begin
               if (sync2) begin
                  state_nxt = S_HIGH;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = S_LOW;
                  level_nxt = 1'b0;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
               level_nxt = 1'b0;
            end
         endcase
      end

      assign btn_level[i] = level;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      logic [LONG_CNT_W-1:0] lcnt;
      logic                  long_q;

      // lcnt follows the registered level, so a release that the filter
      // rejects never touches it. Saturating at LONG_CYC means the
      // LONG_LAST -> LONG_MAX step, and therefore the pulse, happens once
      // per press no matter how long the button is held.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            lcnt   <= '0;
            long_q <= 1'b0;
         end else begin
            long_q <= level && (lcnt == LONG_LAST);
            if (!level) begin
               lcnt <= '0;
            end else if (lcnt < LONG_MAX) begin
               lcnt <= lcnt + 1'b1;
            end
         end
      end

      assign btn_long[i] = long_q;
`endif

   end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - vector-table and scoreboard bench for button_debouncer

module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   localparam bit LONG_ON = 1'b1;
`else
   localparam bit LONG_ON = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic [3:0] btn_long;

   button_debouncer #(
      .BTN_W       (4),
      .CNT_W       (4),
      .DEBOUNCE_CYC(4),
      .LONG_CNT_W  (5),
      .LONG_CYC    (10)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_long (btn_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per clock edge: inputs applied before the edge, outputs
   // expected right after it.
   typedef struct {
      string      name;
      logic       rst_n;
      logic [3:0] raw;
      logic [3:0] lvl;
      logic [3:0] lng;
   } vec_t;

   typedef struct {
      string      name;
      int         idx;
      logic [3:0] lvl;
      logic [3:0] lng;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_cmp;
   int   n_bad;

   task automatic add(input string name, input logic rst_n, input logic [3:0] raw,
                      input logic [3:0] lvl, input logic [3:0] lng);
      vec_t v;
      v.name  = name;
      v.rst_n = rst_n;
      v.raw   = raw;
      v.lvl   = lvl;
      v.lng   = lng;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [3:0] got,
                        input logic [3:0] need);
      n_cmp++;
      if (got !== need) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %b, required %b", name, idx, got, need);
      end
   endtask

   initial begin
      exp_t       e;
      logic [4:0] bounce;
      n_cmp   = 0;
      n_bad   = 0;
      reset_n = 1'b0;
      btn_raw = 4'b0000;
      bounce  = 5'b01101;   // j=0..4 -> 1,0,1,1,0

      // Reset and idle.
      for (int j = 0; j < 2; j++) add("reset", 1'b0, 4'b0000, 4'b0000, 4'b0000);
      for (int j = 0; j < 2; j++) add("idle", 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // Clean press on ch0, first high sample at j=0, held 20 edges:
      // level up after edge 6, long pulse 10 edges later, released at 20
      // so level drops after edge 26.
      for (int j = 0; j < 28; j++)
         add("press0", 1'b1, (j < 20) ? 4'b0001 : 4'b0000,
             (j >= 6 && j < 26) ? 4'b0001 : 4'b0000,
             (LONG_ON && j == 16) ? 4'b0001 : 4'b0000);

      // Bounce on ch1: 1,0,1,1,0 then high from j=5 to 11; rise 6 edges
      // after j=5, release at 12 drops level after edge 18.
      for (int j = 0; j < 20; j++)
         add("bounce1", 1'b1,
             ((j < 5) ? bounce[j] : (j < 12)) ? 4'b0010 : 4'b0000,
             (j >= 11 && j < 18) ? 4'b0010 : 4'b0000, 4'b0000);

      // Release glitch on ch2: 3 low samples after level rose, rejected;
      // lcnt keeps counting so the long pulse still lands at j=16.
      for (int j = 0; j < 26; j++)
         add("glitch2", 1'b1,
             (j < 7 || (j >= 10 && j < 18)) ? 4'b0100 : 4'b0000,
             (j >= 6 && j < 24) ? 4'b0100 : 4'b0000,
             (LONG_ON && j == 16) ? 4'b0100 : 4'b0000);

      // Reset mid-press on ch3 at j=8 with the pin held: level cleared,
      // new first sample at j=9, level back after edge 15.
      for (int j = 0; j < 25; j++)
         add("rst3", (j != 8), (j < 17) ? 4'b1000 : 4'b0000,
             ((j >= 6 && j < 8) || (j >= 15 && j < 23)) ? 4'b1000 : 4'b0000,
             4'b0000);

      // Second press on ch0 pulses again.
      for (int j = 0; j < 26; j++)
         add("press0b", 1'b1, (j < 18) ? 4'b0001 : 4'b0000,
             (j >= 6 && j < 24) ? 4'b0001 : 4'b0000,
             (LONG_ON && j == 16) ? 4'b0001 : 4'b0000);

      // All channels together, independent and identical timing.
      for (int j = 0; j < 16; j++)
         add("all", 1'b1, (j < 8) ? 4'b1111 : 4'b0000,
             (j >= 6 && j < 14) ? 4'b1111 : 4'b0000, 4'b0000);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset_n = vecs[i].rst_n;
         btn_raw = vecs[i].raw;
         e.name  = vecs[i].name;
         e.idx   = i;
         e.lvl   = vecs[i].lvl;
         e.lng   = vecs[i].lng;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard vec %0d: queue empty, required 1 entry", i);
         end else begin
            e = exp_q.pop_front();
            check({e.name, ".level"}, e.idx, btn_level, e.lvl);
            check({e.name, ".long"}, e.idx, btn_long, e.lng);
         end
      end

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
